// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: groups the hazard, redirect, trap and debug request lines
// and the per-stage control outputs of the pipeline control sequencer.
//   master : request side (hazard unit, ID stage, debug module)
//   slave  : the sequencer (pipeline_ctrl)
// Optional: PIPE_PERF_CNT_EN adds the 32-bit stall_cnt line.
interface pipeline_ctrl_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                stall_req;
    logic                redirect_req;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                exc_req;
    logic [PC_WIDTH-1:0] exc_pc;
    logic [PC_WIDTH-1:0] trap_vec;
    logic                dbg_halt_req;
    logic                dbg_resume_req;

    logic                pc_we;
    logic                pc_load;
    logic [PC_WIDTH-1:0] next_pc;
    logic                ifid_en;
    logic                ifid_flush;
    logic                idex_flush;
    logic [PC_WIDTH-1:0] epc;
    logic                exc_ack;
    logic                dbg_halted;
    logic [1:0]          ctrl_state;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]         stall_cnt;
`endif

    modport master (
        output stall_req, redirect_req, redirect_pc, exc_req, exc_pc, trap_vec,
               dbg_halt_req, dbg_resume_req,
`ifdef PIPE_PERF_CNT_EN
        input  stall_cnt,
`endif
        input  pc_we, pc_load, next_pc, ifid_en, ifid_flush, idex_flush, epc,
               exc_ack, dbg_halted, ctrl_state
    );

    modport slave (
        input  stall_req, redirect_req, redirect_pc, exc_req, exc_pc, trap_vec,
               dbg_halt_req, dbg_resume_req,
`ifdef PIPE_PERF_CNT_EN
        output stall_cnt,
`endif
        output pc_we, pc_load, next_pc, ifid_en, ifid_flush, idex_flush, epc,
               exc_ack, dbg_halted, ctrl_state
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline control sequencer for the rv32i five-stage core.
// Turns hazard stalls, ID-stage redirects, ID-stage exceptions and debug
// halt/resume requests into PC / IF/ID / ID/EX controls. Exceptions and halts
// first drain EX/MEM/WB for DRAIN_CYCLES cycles, then trap or halt.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset; forces safe outputs while high
//   bus  : pipeline_ctrl_if.slave (requests in, stage controls / epc / state out)
// Optional: define PIPE_PERF_CNT_EN to add bus.stall_cnt, a free-running count
// of frozen cycles cleared only by rst.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned PC_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_ctrl_if.slave         bus
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StTrap  = 2'd2,
        StHalt  = 2'd3
    } state_e;

    localparam logic CauseTrap = 1'b0;
    localparam logic CauseHalt = 1'b1;
    localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES - 1);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                cause_q, cause_d;
    logic [PC_WIDTH-1:0] epc_q, epc_d;

    logic                pc_we, pc_load, ifid_en, ifid_flush, idex_flush;
    logic                exc_ack, dbg_halted;
    logic [PC_WIDTH-1:0] next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            cause_q <= CauseTrap;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        pc_we      = 1'b0;
        pc_load    = 1'b0;
        next_pc    = '0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exc_ack    = 1'b0;
        dbg_halted = 1'b0;

        unique case (state_q)
            StRun: begin
                if (bus.exc_req) begin
                    epc_d      = bus.exc_pc;
                    idex_flush = 1'b1;
                    cnt_d      = DrainLoad;
                    cause_d    = CauseTrap;
                    state_d    = StDrain;
                end else if (bus.dbg_halt_req) begin
                    idex_flush = 1'b1;
                    cnt_d      = DrainLoad;
                    cause_d    = CauseHalt;
                    state_d    = StDrain;
                end else if (bus.stall_req) begin
                    // Redirect alongside a stall uses stale operands; hazard unit re-presents it.
                    idex_flush = 1'b1;
                end else if (bus.redirect_req) begin
                    pc_we      = 1'b1;
                    pc_load    = 1'b1;
                    next_pc    = bus.redirect_pc;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_we   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
            StDrain: begin
                idex_flush = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = (cause_q == CauseTrap) ? StTrap : StHalt;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StTrap: begin
                pc_we      = 1'b1;
                pc_load    = 1'b1;
                next_pc    = bus.trap_vec;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                exc_ack    = 1'b1;
                state_d    = StRun;
            end
            StHalt: begin
                // IF/ID held (ifid_en=0) so execution resumes from the same instruction.
                idex_flush = 1'b1;
                dbg_halted = 1'b1;
                if (bus.dbg_resume_req) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        if (rst) begin
            bus.pc_we      = 1'b0;
            bus.pc_load    = 1'b0;
            bus.next_pc    = '0;
            bus.ifid_en    = 1'b0;
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            bus.exc_ack    = 1'b0;
            bus.dbg_halted = 1'b0;
            bus.ctrl_state = 2'd0;
        end else begin
            bus.pc_we      = pc_we;
            bus.pc_load    = pc_load;
            bus.next_pc    = next_pc;
            bus.ifid_en    = ifid_en;
            bus.ifid_flush = ifid_flush;
            bus.idex_flush = idex_flush;
            bus.exc_ack    = exc_ack;
            bus.dbg_halted = dbg_halted;
            bus.ctrl_state = state_q;
        end
    end

    assign bus.epc = epc_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic        frozen;

    // A RUN cycle counts when the front end is frozen (stall or trap/halt entry).
    assign frozen = (state_q != StRun) ||
                    bus.stall_req || bus.exc_req || bus.dbg_halt_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (frozen) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed, table-driven bench for pipeline_ctrl
// (DRAIN_CYCLES=3, PC_WIDTH=32), plus hand-written multi-cycle sequences.
module tb_pipeline_ctrl;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    pipeline_ctrl_if #(.PC_WIDTH(32)) bus ();

    pipeline_ctrl #(
        .DRAIN_CYCLES(3),
        .PC_WIDTH    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exc;
        logic [31:0] epc_in;
        logic [31:0] tvec;
        logic        halt;
        logic        resume;
        logic        e_pc_we;
        logic        e_pc_load;
        logic [31:0] e_next_pc;
        logic        e_ifid_en;
        logic        e_ifid_flush;
        logic        e_idex_flush;
        logic [31:0] e_epc;
        logic        e_ack;
        logic        e_halted;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall_req      = 1'b0;
        bus.redirect_req   = 1'b0;
        bus.redirect_pc    = '0;
        bus.exc_req        = 1'b0;
        bus.exc_pc         = '0;
        bus.trap_vec       = '0;
        bus.dbg_halt_req   = 1'b0;
        bus.dbg_resume_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic add(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ex, input logic [31:0] epi, input logic [31:0] tv,
                       input logic h, input logic rs,
                       input logic we, input logic ld, input logic [31:0] np, input logic ie,
                       input logic ifl, input logic idf, input logic [31:0] ep,
                       input logic ak, input logic hd, input logic [1:0] cs);
        vec_t v;
        v = '{r, st, rd, rpc, ex, epi, tv, h, rs, we, ld, np, ie, ifl, idf, ep, ak, hd, cs};
        vecs.push_back(v);
    endtask

    initial begin
        int exp_st[10];
        int lat;
        int ack_seen;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();

        //   rst st rd rpc     ex epc_in  tvec    h rs | we ld next    ie ifl idf epc     ak hd cs
        add(1, 0, 1, 32'h44, 1, 32'h99, 32'h0,   0, 0,   0, 0, 32'h0,  0, 1, 1, 32'h0,   0, 0, 0);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 0,   1, 0, 32'h0,  1, 0, 0, 32'h0,   0, 0, 0);
        add(0, 1, 1, 32'h80, 0, 32'h0,  32'h0,   0, 0,   0, 0, 32'h0,  0, 0, 1, 32'h0,   0, 0, 0);
        add(0, 0, 1, 32'h40, 0, 32'h0,  32'h0,   0, 0,   1, 1, 32'h40, 1, 1, 0, 32'h0,   0, 0, 0);
        add(0, 1, 0, 32'h0,  0, 32'h0,  32'h0,   0, 0,   0, 0, 32'h0,  0, 0, 1, 32'h0,   0, 0, 0);
        // Trap at T: exception outranks stall/redirect
        add(0, 1, 1, 32'h60, 1, 32'h100,32'h800, 0, 0,   0, 0, 32'h0,  0, 0, 1, 32'h0,   0, 0, 0);
        add(0, 0, 0, 32'h0,  1, 32'h200,32'h800, 1, 0,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 0, 1);
        add(0, 1, 1, 32'h64, 0, 32'h0,  32'h800, 0, 0,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 0, 1);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h800, 0, 0,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 0, 1);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h800, 0, 0,   1, 1, 32'h800,0, 1, 1, 32'h100, 1, 0, 2);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 0,   1, 0, 32'h0,  1, 0, 0, 32'h100, 0, 0, 0);
        // Debug halt pulse, resume ignored while draining, halt ignored while halted
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   1, 0,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 0, 0);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 0,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 0, 1);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 1,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 0, 1);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 0,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 0, 1);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   1, 0,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 1, 3);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 0,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 1, 3);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 1,   0, 0, 32'h0,  0, 0, 1, 32'h100, 0, 1, 3);
        add(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 0,   1, 0, 32'h0,  1, 0, 0, 32'h100, 0, 0, 0);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            rst                = vecs[i].rst;
            bus.stall_req      = vecs[i].stall;
            bus.redirect_req   = vecs[i].redir;
            bus.redirect_pc    = vecs[i].rpc;
            bus.exc_req        = vecs[i].exc;
            bus.exc_pc         = vecs[i].epc_in;
            bus.trap_vec       = vecs[i].tvec;
            bus.dbg_halt_req   = vecs[i].halt;
            bus.dbg_resume_req = vecs[i].resume;
            #3;
            check($sformatf("v%0d.pc_we", i),      32'(bus.pc_we),      32'(vecs[i].e_pc_we));
            check($sformatf("v%0d.pc_load", i),    32'(bus.pc_load),    32'(vecs[i].e_pc_load));
            check($sformatf("v%0d.next_pc", i),    bus.next_pc,         vecs[i].e_next_pc);
            check($sformatf("v%0d.ifid_en", i),    32'(bus.ifid_en),    32'(vecs[i].e_ifid_en));
            check($sformatf("v%0d.ifid_flush", i), 32'(bus.ifid_flush), 32'(vecs[i].e_ifid_flush));
            check($sformatf("v%0d.idex_flush", i), 32'(bus.idex_flush), 32'(vecs[i].e_idex_flush));
            check($sformatf("v%0d.epc", i),        bus.epc,             vecs[i].e_epc);
            check($sformatf("v%0d.exc_ack", i),    32'(bus.exc_ack),    32'(vecs[i].e_ack));
            check($sformatf("v%0d.dbg_halted", i), 32'(bus.dbg_halted), 32'(vecs[i].e_halted));
            check($sformatf("v%0d.ctrl_state", i), 32'(bus.ctrl_state), 32'(vecs[i].e_state));
            next_cycle();
        end

        // Simultaneous exception and held halt: trap first, then drain again into HALT.
        idle_inputs();
        rst = 1'b0;
        bus.exc_req      = 1'b1;
        bus.dbg_halt_req = 1'b1;
        bus.exc_pc       = 32'h300;
        bus.trap_vec     = 32'h900;
        exp_st = '{0, 1, 1, 1, 2, 0, 1, 1, 1, 3};
        for (int k = 0; k < 10; k++) begin
            #3;
            check($sformatf("sim.state%0d", k), 32'(bus.ctrl_state), 32'(exp_st[k]));
            if (k == 4) begin
                check("sim.ack", 32'(bus.exc_ack), 32'd1);
                check("sim.next_pc", bus.next_pc, 32'h900);
            end
            if (k == 5) check("sim.run_frozen", 32'(bus.pc_we), 32'd0);
            if (k == 9) begin
                check("sim.halted", 32'(bus.dbg_halted), 32'd1);
                check("sim.epc", bus.epc, 32'h300);
            end
            next_cycle();
            if (k == 0) bus.exc_req = 1'b0;
        end
        bus.dbg_halt_req   = 1'b0;
        bus.dbg_resume_req = 1'b1;
        #3;
        check("sim.resume_cycle", 32'(bus.ctrl_state), 32'd3);
        next_cycle();
        bus.dbg_resume_req = 1'b0;
        #3;
        check("sim.resumed_state", 32'(bus.ctrl_state), 32'd0);
        check("sim.resumed_pc_we", 32'(bus.pc_we), 32'd1);
        check("sim.resumed_pc_load", 32'(bus.pc_load), 32'd0);
        next_cycle();

        // Reset in the middle of DRAIN drops the pending trap.
        bus.exc_req = 1'b1;
        bus.exc_pc  = 32'h500;
        #3;
        next_cycle();
        bus.exc_req = 1'b0;
        #3;
        check("rst.drain_state", 32'(bus.ctrl_state), 32'd1);
        check("rst.epc_captured", bus.epc, 32'h500);
        next_cycle();
        rst = 1'b1;
        #3;
        check("rst.forced_state", 32'(bus.ctrl_state), 32'd0);
        check("rst.forced_ifid_flush", 32'(bus.ifid_flush), 32'd1);
        check("rst.forced_pc_we", 32'(bus.pc_we), 32'd0);
        next_cycle();
        rst = 1'b0;
        #3;
        check("rst.run_state", 32'(bus.ctrl_state), 32'd0);
        check("rst.epc_cleared", bus.epc, 32'h0);
        check("rst.pc_we", 32'(bus.pc_we), 32'd1);
        ack_seen = 0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            #3;
            if (bus.exc_ack) ack_seen++;
        end
        check("rst.no_ack", 32'(ack_seen), 32'd0);
        next_cycle();

        // Halt latency, bounded wait.
        bus.dbg_halt_req = 1'b1;
        #3;
        next_cycle();
        bus.dbg_halt_req = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            #3;
            if (bus.dbg_halted) begin
                lat = c;
                break;
            end
            next_cycle();
        end
        check("halt.latency", 32'(lat), 32'd4);
        next_cycle();
        bus.dbg_resume_req = 1'b1;
        next_cycle();
        bus.dbg_resume_req = 1'b0;
        #3;
        check("halt.resumed", 32'(bus.ctrl_state), 32'd0);
        next_cycle();

`ifdef PIPE_PERF_CNT_EN
        do_reset();
        #3;
        check("perf.reset", bus.stall_cnt, 32'd0);
        next_cycle();
        bus.stall_req = 1'b1;
        next_cycle();
        next_cycle();
        bus.stall_req = 1'b0;
        bus.exc_req   = 1'b1;
        bus.exc_pc    = 32'h100;
        bus.trap_vec  = 32'h800;
        next_cycle();
        bus.exc_req = 1'b0;
        for (int c = 0; c < 4; c++) next_cycle();
        #3;
        check("perf.count", bus.stall_cnt, 32'd7);
        next_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
